// File: rtl/demux_dispatch_ctrl_pkg.sv
// Shared types and constants for the 8-way demux dispatch controller.
package demux_dispatch_ctrl_pkg;

    localparam int unsigned NR_OF_CHANNELS = 8;
    localparam int unsigned SEL_WIDTH      = 3;
    localparam int unsigned COUNT_WIDTH    = 16;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } dispatchStateT;

    // Channel select to one-hot valid vector.
    function automatic logic [NR_OF_CHANNELS-1:0] oneHot(input logic [SEL_WIDTH-1:0] sel);
        logic [NR_OF_CHANNELS-1:0] vec;
        vec      = '0;
        vec[sel] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/demux_dispatch_ctrl_rr_pointer.sv
// Round-robin channel pointer: advances by one per round-robin capture, wraps 7 -> 0.
module dispatch_rr_pointer
    import demux_dispatch_ctrl_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 advance,
    output logic [SEL_WIDTH-1:0] ptr
);

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= ptr + SEL_WIDTH'(1);
        end
    end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Single-word holding dispatcher feeding an 8-way bus demux, round-robin or addressed.
// Optional build macro DISPATCH_STATS_EN adds a saturating dispatch_count output.
module demux_dispatch_ctrl
    import demux_dispatch_ctrl_pkg::*;
#(
    parameter int unsigned nrOfBits = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [nrOfBits-1:0]       in_data,
    input  logic [SEL_WIDTH-1:0]      in_dest,
    input  logic                      mode,
    input  logic [NR_OF_CHANNELS-1:0] out_ready,
    output logic [NR_OF_CHANNELS-1:0] out_valid,
    output logic [SEL_WIDTH-1:0]      demux_sel,
    output logic                      demux_enable,
    output logic [nrOfBits-1:0]       demux_data
`ifdef DISPATCH_STATS_EN
    ,
    output logic [COUNT_WIDTH-1:0]    dispatch_count
`endif
);

    dispatchStateT          state;
    dispatchStateT          stateNext;
    logic [nrOfBits-1:0]    dataQ;
    logic [SEL_WIDTH-1:0]   destQ;
    logic [SEL_WIDTH-1:0]   rrPtr;
    logic                   capture;
    logic                   transfer;

    // Reset gates the handshake so nothing moves during the reset cycle.
    assign transfer = !reset && (state == HOLD) && out_ready[destQ];
    assign in_ready = !reset && ((state == IDLE) || transfer);
    assign capture  = in_valid && in_ready;

    dispatch_rr_pointer uRrPointer (
        .clock   (clock),
        .reset   (reset),
        .advance (capture && !mode),
        .ptr     (rrPtr)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (capture) begin
                    stateNext = HOLD;
                end
            end
            HOLD: begin
                if (transfer && !capture) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Holding register; destination mode is only looked at on capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            dataQ <= '0;
            destQ <= '0;
        end else if (capture) begin
            dataQ <= in_data;
            destQ <= mode ? in_dest : rrPtr;
        end
    end

    // Demux drive outputs
    always_comb begin
        out_valid    = '0;
        demux_sel    = '0;
        demux_enable = 1'b0;
        demux_data   = '0;
        if ((state == HOLD) && !reset) begin
            out_valid    = oneHot(destQ);
            demux_sel    = destQ;
            demux_enable = 1'b1;
            demux_data   = dataQ;
        end
    end

`ifdef DISPATCH_STATS_EN
    // Completed-transfer counter, sticks at all-ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            dispatch_count <= '0;
        end else if (transfer && (dispatch_count != {COUNT_WIDTH{1'b1}})) begin
            dispatch_count <= dispatch_count + COUNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: doc/demux_dispatch_ctrl.md
DEMUX_DISPATCH_CTRL -- requirements
Module: demux_dispatch_ctrl

Interface
REQ-001 Parameter: nrOfBits, default 8, data word width.
REQ-002 Port: clock  in  1  sole clock; all state changes on rising edge.
REQ-003 Port: reset  in  1  reset, synchronous and active-high.
REQ-004 Port: in_valid  in  1  upstream word present.
REQ-005 Port: in_ready  out  1  controller accepts the word this cycle.
REQ-006 Port: in_data  in  nrOfBits  upstream word.
REQ-007 Port: in_dest  in  3  destination channel, used in addressed mode only.
REQ-008 Port: mode  in  1  0 = round-robin, 1 = addressed.
REQ-009 Port: out_ready  in  8  per-channel downstream ready.
REQ-010 Port: out_valid  out  8  per-channel valid, at most one bit high.
REQ-011 Port: demux_sel  out  3  channel select driven to the 8-way bus demultiplexer.
REQ-012 Port: demux_enable  out  1  demultiplexer enable.
REQ-013 Port: demux_data  out  nrOfBits  held word driven to the demultiplexer input.

Function
REQ-014 The FSM SHALL have two states: IDLE (holding register empty) and HOLD (one word held for channel dest_q).
REQ-015 Capture: in_valid && in_ready at edge N SHALL load data_q and dest_q; out_valid[dest_q] SHALL be high from cycle N+1, giving 1-cycle latency.
REQ-016 Destination rule: dest_q = in_dest when mode=1; dest_q = rr_ptr when mode=0; mode SHALL be sampled only at capture.
REQ-017 In HOLD: demux_enable=1, demux_sel=dest_q, demux_data=data_q, out_valid=one-hot(dest_q). In IDLE: all four SHALL be 0.
REQ-018 Transfer: in HOLD, out_ready[dest_q]=1 completes the transfer. out_ready bits for other channels SHALL be ignored.
REQ-019 in_ready SHALL equal (state==IDLE) || (state==HOLD && out_ready[dest_q]), giving full throughput of 1 word/cycle.
REQ-020 Simultaneous transfer and capture SHALL stay in HOLD with the new word. With no new capture, a transfer SHALL move to IDLE.
REQ-021 rr_ptr SHALL increment by 1 and wrap from 7 to 0 on each capture made in mode=0. Captures in mode=1 SHALL leave rr_ptr unchanged.
REQ-022 A held word SHALL stay stable (data, sel, valid) until transferred, whatever in_valid, mode or in_dest do.

Reset
REQ-023 While reset=1 at an edge: state=IDLE, rr_ptr=0, data_q=0, dest_q=0.
REQ-024 During the reset cycle, all outputs SHALL read 0, including in_ready. in_ready SHALL be 1 from the first cycle after reset deasserts.
REQ-025 Reset mid-HOLD SHALL discard the held word; no transfer occurs in that cycle.

Configuration
REQ-026 Macro DISPATCH_STATS_EN: when defined, add output dispatch_count (16 bits).
- It counts completed transfers and saturates at 0xFFFF.
- Reset clears it to 0.
- When undefined, the port and counter SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-027 The shared package SHALL hold: the FSM state enum (IDLE, HOLD), the constant NR_OF_CHANNELS=8, and the constant SEL_WIDTH=3.
REQ-028 The round-robin pointer SHALL be one sub-module, dispatch_rr_pointer, with inputs clock, reset, advance and output ptr[2:0].

Verification
REQ-029 Reset, then mode=0, in_valid=1 for 9 words 0x10..0x18, out_ready=8'hFF:
- words appear on channels 0,1,...,7,0 on consecutive cycles;
- in_ready stays 1 throughout.
REQ-030 Addressed backpressure: mode=1, in_dest=5, data=0xA5, out_ready=0 for 4 cycles:
- out_valid=8'h20 and demux_data=0xA5 are held stable;
- in_ready=0;
- out_ready[5]=1 completes the transfer next cycle;
- out_ready[3]=1 alone has no effect.
REQ-031 Mode switch: capture 0x01 in mode=0 (channel 0), then set mode=1 with in_dest=6 before the transfer:
- word 0x01 still goes to channel 0;
- the next word goes to channel 6;
- rr_ptr stays at 1.
REQ-032 Reset asserted during HOLD with out_valid=8'h04:
- the next cycle shows all outputs 0 and rr_ptr=0;
- the first post-reset round-robin word goes to channel 0.
REQ-033 With DISPATCH_STATS_EN defined, 70000 back-to-back transfers leave dispatch_count=0xFFFF.
REQ-034 Without DISPATCH_STATS_EN, the same bench minus dispatch_count checks SHALL pass.
